// File: rtl/nm_link_pkg.sv
// -----------------------------------------------------------------------------
// nm_link_pkg
// Shared definitions for the nm_link uplink transmitter:
//   - link_state_e : transmitter FSM state encoding
//   - clog2_min1   : ceil(log2(n)), never less than 1
//   - calc_id_w    : width of the source ID field
//   - calc_frame_len : bits per frame (start + ID + data [+ parity])
//   - DBG_*        : bit positions on the debug bus
// Build option: NM_LINK_PARITY_EN appends an even-parity bit to every frame.
// -----------------------------------------------------------------------------
package nm_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } link_state_e;

`ifdef NM_LINK_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Debug bus bit positions; bits above DBG_BUSY read as zero.
    localparam int DBG_ANY_VALID = 0;
    localparam int DBG_N2C_DATA  = 1;
    localparam int DBG_BIT_STB   = 2;
    localparam int DBG_BUSY      = 3;

    function automatic int clog2_min1(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int calc_id_w(input int n_src);
        return clog2_min1(n_src);
    endfunction

    function automatic int calc_frame_len(input int id_w, input int word_w);
        return 1 + id_w + word_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/nm_link_arb.sv
// -----------------------------------------------------------------------------
// nm_link_arb
// Combinational source selector for the uplink transmitter plus the registered
// round-robin pointer.
//   clk, rstb     : clock, asynchronous active-low reset
//   rr_en         : 0 = lowest asserted index wins, 1 = round robin
//   req           : per-source request (src_valid)
//   grant_en      : a grant is being taken this cycle; updates the pointer
//   any_req       : at least one request asserted
//   grant_idx     : index of the selected source
//   grant_onehot  : one-hot form of grant_idx (all zero when no request)
// The round-robin search starts one past the last granted source, so after
// reset (pointer 0) index 1 is searched first.
// -----------------------------------------------------------------------------
module nm_link_arb
    import nm_link_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = calc_id_w(N_SRC)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             rr_en,
    input  logic [N_SRC-1:0] req,
    input  logic             grant_en,
    output logic             any_req,
    output logic [ID_W-1:0]  grant_idx,
    output logic [N_SRC-1:0] grant_onehot
);

    logic [ID_W-1:0]    last_grant_r;
    logic [2*N_SRC-1:0] req_dbl_s;
    logic [N_SRC-1:0]   req_rot_s;
    int                 start_s;
    int                 pick_raw_s;
    logic               found_s;

    // Search origin: fixed priority always starts at 0, round robin one past
    // the last grant with wrap-around.
    always_comb begin
        start_s = 0;
        if (rr_en && (int'(last_grant_r) < (N_SRC - 1))) begin
            start_s = int'(last_grant_r) + 32'sd1;
        end else begin
            start_s = 0;
        end
    end

    // Rotate the requests so the search origin lands on bit 0, then take the
    // lowest set bit; duplicating the vector makes the rotation a plain shift.
    always_comb begin
        req_dbl_s  = {req, req};
        req_rot_s  = N_SRC'(req_dbl_s >> start_s);
        found_s    = 1'b0;
        pick_raw_s = start_s;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found_s && req_rot_s[k]) begin
                found_s    = 1'b1;
                pick_raw_s = start_s + k;
            end else begin
                found_s    = found_s;
            end
        end
    end

    assign grant_idx    = ID_W'((pick_raw_s >= N_SRC) ? (pick_raw_s - N_SRC) : pick_raw_s);
    assign any_req      = |req;
    assign grant_onehot = any_req ? (N_SRC'(1'b1) << grant_idx) : {N_SRC{1'b0}};

    // Round-robin pointer: moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_grant_r <= {ID_W{1'b0}};
        end else if (grant_en) begin
            last_grant_r <= grant_idx;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/nm_link_tx.sv
// -----------------------------------------------------------------------------
// nm_link_tx
// Neural-module uplink transmitter. Arbitrates N_SRC parallel word sources
// onto the single serial n2c line. Each frame is a start bit (1), the source
// ID MSB-first, the data word MSB-first and, with NM_LINK_PARITY_EN defined,
// an even-parity bit over ID+data. Every bit is held CLK_DIV clocks; each
// frame is followed by one gap bit of 0 and arbitration resumes one bit
// strobe after the gap.
//   clk, rstb   : clock, asynchronous active-low reset (aborts any frame)
//   run         : permits new grants; a frame in progress always completes
//   rr_en       : 0 = fixed priority (lowest index), 1 = round robin
//   src_valid   : per-source word pending, sampled on the grant cycle only
//   src_data    : flattened words, source i at [i*WORD_W +: WORD_W]
//   src_ready   : one-cycle, one-hot accept pulse in the grant cycle
//   n2c_data    : registered serial output, idle 0
//   busy        : frame or gap in progress
//   grant_id    : source of the current/last frame
//   debug       : {zeros, busy, bit_stb, n2c_data, any_valid}
// Build option: NM_LINK_PARITY_EN (adds the parity bit, FRAME_LEN + 1).
// -----------------------------------------------------------------------------
module nm_link_tx
    import nm_link_pkg::*;
#(
    parameter  int N_SRC          = 4,
    parameter  int WORD_W         = 16,
    parameter  int CLK_DIV        = 10,
    parameter  int DEBUG_BUS_SIZE = 4,
    localparam int ID_W           = calc_id_w(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      run,
    input  logic                      rr_en,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*WORD_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    output logic                      n2c_data,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [DEBUG_BUS_SIZE-1:0] debug
);

    localparam int FRAME_LEN = calc_frame_len(ID_W, WORD_W);
    // Everything after the start bit lives in the shift register.
    localparam int PAY_W     = FRAME_LEN - 1;
    localparam int DIV_W     = clog2_min1(CLK_DIV);
    localparam int CNT_W     = clog2_min1(FRAME_LEN);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

`ifdef NM_LINK_PARITY_EN
    // Even parity: the appended bit makes the count of ones over ID+data+parity even.
    function automatic logic even_parity(input logic [ID_W+WORD_W-1:0] bits);
        return ^bits;
    endfunction
`endif

    // Registers
    logic [DIV_W-1:0] div_cnt_r;
    link_state_e      state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [PAY_W-1:0] shreg_r;
    logic             n2c_data_r;
    logic             busy_r;
    logic [ID_W-1:0]  grant_id_r;

    // Next-state / combinational signals
    link_state_e      state_next_s;
    logic [CNT_W-1:0] bit_cnt_next_s;
    logic [PAY_W-1:0] shreg_next_s;
    logic             n2c_next_s;
    logic [ID_W-1:0]  grant_id_next_s;
    logic             grant_s;
    logic             bit_stb_s;
    logic             arb_any_s;
    logic [ID_W-1:0]  arb_idx_s;
    logic [N_SRC-1:0] arb_onehot_s;
    logic [WORD_W-1:0] data_sel_s;
    logic [PAY_W-1:0] payload_s;

    nm_link_arb #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .clk          (clk),
        .rstb         (rstb),
        .rr_en        (rr_en),
        .req          (src_valid),
        .grant_en     (grant_s),
        .any_req      (arb_any_s),
        .grant_idx    (arb_idx_s),
        .grant_onehot (arb_onehot_s)
    );

    // Bit-rate divider, free-running from reset; the strobe marks each bit boundary.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign bit_stb_s = (div_cnt_r == {DIV_W{1'b0}});

    // One-hot AND-OR mux of the winning source's word.
    always_comb begin
        data_sel_s = {WORD_W{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            data_sel_s = data_sel_s | ({WORD_W{arb_onehot_s[i]}} & src_data[i*WORD_W +: WORD_W]);
        end
    end

`ifdef NM_LINK_PARITY_EN
    assign payload_s = {arb_idx_s, data_sel_s, even_parity({arb_idx_s, data_sel_s})};
`else
    assign payload_s = {arb_idx_s, data_sel_s};
`endif

    // FSM next state, shift register and line value. bit_cnt counts the
    // payload bits still to go; at zero the next strobe drops the line for the gap.
    always_comb begin
        state_next_s    = state_r;
        bit_cnt_next_s  = bit_cnt_r;
        shreg_next_s    = shreg_r;
        n2c_next_s      = n2c_data_r;
        grant_id_next_s = grant_id_r;
        grant_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bit_stb_s && run && arb_any_s) begin
                    grant_s         = 1'b1;
                    shreg_next_s    = payload_s;
                    bit_cnt_next_s  = CNT_LOAD;
                    n2c_next_s      = 1'b1;
                    grant_id_next_s = arb_idx_s;
                    state_next_s    = ST_SEND;
                end else begin
                    n2c_next_s      = 1'b0;
                end
            end
            ST_SEND: begin
                if (bit_stb_s) begin
                    if (bit_cnt_r != {CNT_W{1'b0}}) begin
                        n2c_next_s     = shreg_r[PAY_W-1];
                        shreg_next_s   = {shreg_r[PAY_W-2:0], 1'b0};
                        bit_cnt_next_s = bit_cnt_r - CNT_W'(1);
                    end else begin
                        n2c_next_s     = 1'b0;
                        state_next_s   = ST_GAP;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_GAP: begin
                n2c_next_s = 1'b0;
                if (bit_stb_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                n2c_next_s   = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            shreg_r    <= {PAY_W{1'b0}};
            n2c_data_r <= 1'b0;
            busy_r     <= 1'b0;
            grant_id_r <= {ID_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shreg_r    <= shreg_next_s;
            n2c_data_r <= n2c_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            grant_id_r <= grant_id_next_s;
        end
    end

    // The accept pulse must coincide with the capture edge, so it is decoded
    // directly from the grant decision rather than registered.
    assign src_ready = {N_SRC{grant_s}} & arb_onehot_s;
    assign n2c_data  = n2c_data_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

    // Debug tap.
    always_comb begin
        debug                = {DEBUG_BUS_SIZE{1'b0}};
        debug[DBG_ANY_VALID] = arb_any_s;
        debug[DBG_N2C_DATA]  = n2c_data_r;
        debug[DBG_BIT_STB]   = bit_stb_s;
        debug[DBG_BUSY]      = busy_r;
    end

endmodule

// File: tb/tb_nm_link_tx.sv
// -----------------------------------------------------------------------------
// tb_nm_link_tx
// Scoreboard bench for nm_link_tx (N_SRC=4, WORD_W=16, CLK_DIV=10). Expected
// frames are predicted from the loaded source words when stimulus is applied;
// a line monitor deserialises n2c_data and pops/compares each frame.
// Works with or without NM_LINK_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_nm_link_tx;

    localparam int N_SRC   = 4;
    localparam int WORD_W  = 16;
    localparam int CLK_DIV = 10;
    localparam int DBG_W   = 4;
    localparam int ID_W    = 2;
`ifdef NM_LINK_PARITY_EN
    localparam int PAR_W   = 1;
`else
    localparam int PAR_W   = 0;
`endif
    localparam int PAY_W     = ID_W + WORD_W + PAR_W;
    localparam int FRAME_LEN = PAY_W + 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [WORD_W-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rstb = 1'b0;
    logic                    run = 1'b0;
    logic                    rr_en = 1'b0;
    logic [N_SRC-1:0]        src_valid = '0;
    logic [N_SRC*WORD_W-1:0] src_data = '0;
    logic [N_SRC-1:0]        src_ready;
    logic                    n2c_data;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;
    logic [DBG_W-1:0]        debug;

    exp_t              exp_q[$];
    logic [WORD_W-1:0] src_q[N_SRC][$];
    int                start_cyc[$];
    int                checks = 0;
    int                errors = 0;
    logic [N_SRC-1:0]  rdy_seen = '0;
    int                cyc = 0;
    int                ready_cnt = 0;
    bit                mon_active = 1'b0;
    int                mon_t = 0;
    logic [PAY_W-1:0]  mon_shift = '0;
    int                model_ptr = 0;

    nm_link_tx #(
        .N_SRC          (N_SRC),
        .WORD_W         (WORD_W),
        .CLK_DIV        (CLK_DIV),
        .DEBUG_BUS_SIZE (DBG_W)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .run       (run),
        .rr_en     (rr_en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .n2c_data  (n2c_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .debug     (debug)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [PAY_W-1:0] exp_payload(input exp_t e);
`ifdef NM_LINK_PARITY_EN
        return {e.id, e.data, ^{e.id, e.data}};
`else
        return {e.id, e.data};
`endif
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N_SRC; i++) begin
            src_valid[i] = (src_q[i].size() > 0);
            src_data[i*WORD_W +: WORD_W] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
        end
    endtask

    // One clock: the word accepted last cycle is retired, next word presented.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_SRC; i++) begin
            if (rdy_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        apply_inputs();
    endtask

    // Reference arbitration over all currently loaded words.
    task automatic predict_all();
        int   used[N_SRC];
        int   left;
        int   id;
        int   s;
        exp_t e;
        left = 0;
        for (int i = 0; i < N_SRC; i++) begin
            used[i] = 0;
            left += src_q[i].size();
        end
        while (left > 0) begin
            id = -1;
            for (int k = 0; k < N_SRC; k++) begin
                s = rr_en ? (model_ptr + 1 + k) % N_SRC : k;
                if (id < 0 && used[s] < src_q[s].size()) id = s;
            end
            e.id   = ID_W'(id);
            e.data = src_q[id][used[id]];
            exp_q.push_back(e);
            used[id]++;
            left--;
            model_ptr = id;
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        for (int i = 0; i < N_SRC; i++) src_q[i].delete();
        apply_inputs();
        exp_q.delete();
        model_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || mon_active || busy) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, exp_q.size(), 0);
        check_val({tag, "_busy"}, busy, 1'b0);
    endtask

    // Line monitor: deserialises frames and compares them with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            rdy_seen = src_ready;
            if (!rstb) begin
                mon_active = 1'b0;
            end else begin
                if (src_ready != '0) begin
                    ready_cnt++;
                    if (exp_q.size() > 0) check_val("ready_onehot", src_ready, 32'd1 << exp_q[0].id);
                    else check_val("ready_unexpected", src_ready, 32'd0);
                end
                if (mon_active) begin
                    mon_t++;
                    if (mon_t == CLK_DIV - 1) check_val("start_hold", n2c_data, 1'b1);
                    if (mon_t > CLK_DIV && (mon_t % CLK_DIV) == CLK_DIV / 2 && mon_t < FRAME_LEN * CLK_DIV)
                        mon_shift = {mon_shift[PAY_W-2:0], n2c_data};
                    if (mon_t == FRAME_LEN * CLK_DIV - 1) check_val("last_bit_hold", n2c_data, mon_shift[0]);
                    if (mon_t == FRAME_LEN * CLK_DIV) begin
                        check_val("gap_low", n2c_data, 1'b0);
                        check_val("gap_busy", busy, 1'b1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check_val("frame_payload", mon_shift, exp_payload(e));
                            check_val("frame_grant_id", grant_id, e.id);
                        end else begin
                            check_val("frame_unexpected", exp_q.size(), 1);
                        end
                        mon_active = 1'b0;
                    end
                end else if (n2c_data) begin
                    mon_active = 1'b1;
                    mon_t      = 0;
                    mon_shift  = '0;
                    start_cyc.push_back(cyc);
                    check_val("start_busy", busy, 1'b1);
                end
            end
        end
    end

    initial begin
        int   first;
        int   second;
        logic any_high;
        int   n;
        exp_t e;

        // Reset state and idle divider
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_n2c", n2c_data, 1'b0);
        check_val("rst_ready", src_ready, 4'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_grant_id", grant_id, 2'd0);
        check_val("rst_debug", debug & 4'b1011, 4'h0);
        rstb = 1'b1;
        first = -1;
        second = -1;
        any_high = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (debug[2]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            any_high = any_high | n2c_data | busy | (|src_ready);
        end
        check_val("stb_first", first, 9);
        check_val("stb_period", second - first, CLK_DIV);
        check_val("idle_quiet", any_high, 1'b0);

        // Single source 2, fixed priority
        run = 1'b1;
        rr_en = 1'b0;
        ready_cnt = 0;
        src_q[2].push_back(16'hA5C3);
        predict_all();
        apply_inputs();
        wait_idle("single_done", 400);
        check_val("single_ready_cnt", ready_cnt, 1);
        check_val("single_grant_id", grant_id, 2'd2);

        // Sources 0 and 3 together, fixed priority: 0 first, then 3
        start_cyc.delete();
        src_q[0].push_back(16'h1234);
        src_q[3].push_back(16'hBEEF);
        predict_all();
        apply_inputs();
        wait_idle("fixed_done", 800);
        check_val("fixed_count", start_cyc.size(), 2);
        if (start_cyc.size() == 2)
            check_val("fixed_spacing", start_cyc[1] - start_cyc[0], (FRAME_LEN + 2) * CLK_DIV);

        // Round robin from reset, all four sources continuously valid
        do_reset();
        run = 1'b1;
        rr_en = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = 0; j < 2; j++) src_q[i].push_back(16'h1000 + 16'(i * 16 + j));
        end
        predict_all();
        apply_inputs();
        wait_idle("rr_done", 2500);
        check_val("rr_ready_cnt", ready_cnt, 8);

        // run dropped at bit 5 of a frame with other sources pending
        rr_en = 1'b0;
        ready_cnt = 0;
        src_q[0].push_back(16'h0F0F);
        src_q[1].push_back(16'h1111);
        src_q[2].push_back(16'h2222);
        e.id = 2'd0;
        e.data = 16'h0F0F;
        exp_q.push_back(e);
        model_ptr = 0;
        apply_inputs();
        n = 0;
        while (!(mon_active && mon_t >= 5 * CLK_DIV) && n < 300) begin
            step();
            n++;
        end
        check_val("rundrop_reach", mon_active, 1'b1);
        run = 1'b0;
        wait_idle("rundrop_frame", 400);
        repeat (300) step();
        check_val("rundrop_ready_cnt", ready_cnt, 1);
        check_val("rundrop_busy", busy, 1'b0);
        check_val("rundrop_n2c", n2c_data, 1'b0);
        src_q[1].delete();
        src_q[2].delete();
        apply_inputs();
        run = 1'b1;

        // Async reset mid-frame while the line is high, then a clean frame
        ready_cnt = 0;
        src_q[0].push_back(16'h0007);
        e.id = 2'd0;
        e.data = 16'h0007;
        exp_q.push_back(e);
        apply_inputs();
        n = 0;
        while (!(mon_active && mon_t >= 17 * CLK_DIV + 2) && n < 400) begin
            step();
            n++;
        end
        check_val("rstmid_pre", n2c_data, 1'b1);
        #2;
        rstb = 1'b0;
        #1;
        check_val("rstmid_n2c", n2c_data, 1'b0);
        check_val("rstmid_busy", busy, 1'b0);
        exp_q.delete();
        model_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        src_q[0].delete();
        src_q[0].push_back(16'h0007);
        predict_all();
        apply_inputs();
        wait_idle("rstmid_restart", 400);
        check_val("rstmid_ready_cnt", ready_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
